// File: rtl/quad_decoder.sv
// rtl/quad_decoder.sv - quadrature decoder with divided wrapping position counter and illegal-transition flag
module quad_decoder #(
    parameter int WIDTH    = 8,
    parameter int DIV_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enc_a,
    input  logic             enc_b,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] count,
    output logic             up_pulse,
    output logic             down_pulse,
    output logic             err_pulse,
    output logic             err_flag
);

    localparam int ACC_W = DIV_LOG2 + 1;
    localparam int SUM_W = DIV_LOG2 + 2;
    localparam logic [SUM_W-1:0] POS_LIM = SUM_W'(2 ** DIV_LOG2);
    localparam logic [SUM_W-1:0] NEG_LIM = ~POS_LIM + SUM_W'(1);

    logic [1:0]       cur_ab;
    logic [1:0]       prev_ab;
    logic             primed;
    logic [ACC_W-1:0] acc;

    logic [1:0]       cur_pos;
    logic [1:0]       prev_pos;
    logic [1:0]       delta;
    logic             step_fwd;
    logic             step_rev;
    logic             step_bad;
    logic [SUM_W-1:0] acc_ext;
    logic [SUM_W-1:0] acc_sum;

    assign cur_ab = {enc_a, enc_b};

    // Gray-to-binary turns the 00,01,11,10 cycle into positions 0..3, so a
    // forward edge is +1 mod 4, reverse is -1 and a double-bit jump is +2.
    assign cur_pos  = {cur_ab[1], cur_ab[1] ^ cur_ab[0]};
    assign prev_pos = {prev_ab[1], prev_ab[1] ^ prev_ab[0]};
    assign delta    = cur_pos - prev_pos;

    assign step_fwd = (delta == 2'd1);
    assign step_rev = (delta == 2'd3);
    assign step_bad = (delta == 2'd2);

    // One extra bit of headroom so the +/-2**DIV_LOG2 limit is representable.
    assign acc_ext = {acc[ACC_W-1], acc};

    always_comb begin
        acc_sum = acc_ext;
        if (step_fwd) begin
            acc_sum = acc_ext + SUM_W'(1);
        end else if (step_rev) begin
            acc_sum = acc_ext - SUM_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count      <= '0;
            acc        <= '0;
            prev_ab    <= 2'b00;
            primed     <= 1'b0;
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            err_flag   <= 1'b0;
        end else begin
            up_pulse   <= 1'b0;
            down_pulse <= 1'b0;
            err_pulse  <= 1'b0;
            prev_ab    <= cur_ab;
            primed     <= 1'b1;
            if (clear) begin
                count    <= '0;
                acc      <= '0;
                err_flag <= 1'b0;
            end else if (load) begin
                count <= load_value;
                acc   <= '0;
            end else if (primed) begin
                if (step_bad) begin
                    err_pulse <= 1'b1;
                    err_flag  <= 1'b1;
                end else if (acc_sum == POS_LIM) begin
                    count    <= count + WIDTH'(1);
                    acc      <= '0;
                    up_pulse <= 1'b1;
                end else if (acc_sum == NEG_LIM) begin
                    count      <= count - WIDTH'(1);
                    acc        <= '0;
                    down_pulse <= 1'b1;
                end else begin
                    acc <= acc_sum[ACC_W-1:0];
                end
            end
        end
    end

endmodule
